cordic_scheduler: RTL and testbench

//  Shares one sin/cos CORDIC core among NUM_REQ requesters, e.g. the robot's wheel-kinematics units.

---
 rtl/cordic_sched_pkg.sv | 8 +
 rtl/cordic_rr_arbiter.sv | 23 ++
 rtl/cordic_scheduler.sv | 152 +++++++++++++++
 tb/tb_cordic_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_sched_pkg.sv
// cordic_sched_pkg: state encoding, angle constants and widths shared by cordic_scheduler
package cordic_sched_pkg;
  localparam int ANG_W = 17;
  localparam int XY_W = 17;
  localparam logic signed [ANG_W-1:0] ANG_90 = 17'sd23040;
  localparam logic signed [ANG_W-1:0] ANG_180 = 17'sd46080;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOAD, S_START, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/cordic_rr_arbiter.sv
// cordic_rr_arbiter: one-hot grant of the first asserted request at or after ptr_i
module cordic_rr_arbiter #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic [PW-1:0] j;
  // Scan from farthest to nearest so the closest request to the pointer wins.
  always_comb begin
    gnt_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = PW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cordic_scheduler.sv
// cordic_scheduler: round-robin sharing of one sin/cos CORDIC core with quadrant folding.
// Define CORDIC_SCHED_TIMEOUT_EN to add a watchdog on the core's valid_out.
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int THETA_BITS = ANG_W - 1,
  parameter int XY_BITS = XY_W - 1,
  parameter logic [XY_BITS:0] CORDIC_X0 = 17'd19899,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*(THETA_BITS+1)-1:0] req_theta,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [XY_BITS:0]                rsp_sin,
  output logic [XY_BITS:0]                rsp_cos,
  output logic                            rsp_err,
  output logic                            cordic_rst,
  output logic                            cordic_init,
  output logic                            cordic_valid_in,
  output logic [XY_BITS:0]                cordic_x_i,
  output logic [XY_BITS:0]                cordic_y_i,
  output logic [THETA_BITS:0]             cordic_theta_i,
  input  logic                            cordic_valid_out,
  input  logic [XY_BITS:0]                cordic_x_o,
  input  logic [XY_BITS:0]                cordic_y_o
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TH = THETA_BITS + 1;
  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, gnt_idx;
  logic signed [THETA_BITS:0] ang_q, ang_d, theta_q, theta_d;
  logic signed [XY_BITS:0] sin_q, sin_d, cos_q, cos_d;
  logic neg_sin_q, neg_sin_d, neg_cos_q, neg_cos_d, err_q, err_d;
  logic [NUM_REQ-1:0] gnt;
  logic oor, tmo_hit;

  cordic_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gnt_idx = PW'(i);
  end

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_q <= '0;
    else tmo_q <= (state_q == S_WAIT) ? tmo_q + TW'(1) : '0;
  assign tmo_hit = (state_q == S_WAIT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign oor = (ang_q > ANG_180) || (ang_q < -ANG_180);

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    ang_d = ang_q;
    theta_d = theta_q;
    neg_sin_d = neg_sin_q;
    neg_cos_d = neg_cos_q;
    err_d = err_q;
    sin_d = sin_q;
    cos_d = cos_q;
    case (state_q)
      S_IDLE: if (|gnt) begin
        idx_d = gnt_idx;
        ang_d = req_theta[gnt_idx*TH +: TH];
        state_d = S_CHECK;
      end
      S_CHECK: if (oor) begin
        err_d = 1'b1;
        sin_d = '0;
        cos_d = '0;
        state_d = S_DONE;
      end else begin
        neg_sin_d = ang_q[THETA_BITS];
        neg_cos_d = (ang_q > ANG_90) || (ang_q < -ANG_90);
        theta_d = (ang_q > ANG_90) ? ANG_180 - ang_q :
                  (ang_q < -ANG_90) ? ang_q + ANG_180 :
                  ang_q[THETA_BITS] ? -ang_q : ang_q;
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: if (cordic_valid_out) begin
        sin_d = neg_sin_q ? -$signed(cordic_y_o) : $signed(cordic_y_o);
        cos_d = neg_cos_q ? -$signed(cordic_x_o) : $signed(cordic_x_o);
        err_d = 1'b0;
        state_d = S_DONE;
      end else if (tmo_hit) begin
        err_d = 1'b1;
        sin_d = '0;
        cos_d = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        ptr_d = (idx_q == PW'(NUM_REQ - 1)) ? '0 : idx_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      ang_q <= '0;
      theta_q <= '0;
      neg_sin_q <= 1'b0;
      neg_cos_q <= 1'b0;
      err_q <= 1'b0;
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      ang_q <= ang_d;
      theta_q <= theta_d;
      neg_sin_q <= neg_sin_d;
      neg_cos_q <= neg_cos_d;
      err_q <= err_d;
      sin_q <= sin_d;
      cos_q <= cos_d;
    end

  assign req_ready = (state_q == S_IDLE) ? gnt : '0;
  assign rsp_valid = (state_q == S_DONE) ? NUM_REQ'(1) << idx_q : '0;
  assign rsp_sin = sin_q;
  assign rsp_cos = cos_q;
  assign rsp_err = err_q;
  assign cordic_rst = ~rst_n;
  assign cordic_init = state_q == S_LOAD;
  assign cordic_valid_in = state_q == S_START;
  assign cordic_x_i = CORDIC_X0;
  assign cordic_y_i = '0;
  assign cordic_theta_i = theta_q;
endmodule

// File: tb/tb_cordic_scheduler.sv
// tb_cordic_scheduler: directed vectors against a fixed-latency stub core with tabulated sin/cos
module tb_cordic_scheduler;
  localparam int N = 4;
  localparam int LAT = 3;
  localparam int TMO = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*17-1:0] req_theta = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [16:0] rsp_sin, rsp_cos, cordic_x_i, cordic_y_i, cordic_theta_i, cordic_x_o, cordic_y_o;
  logic rsp_err, cordic_rst, cordic_init, cordic_valid_in, cordic_valid_out;
  logic stub_en = 1'b1;
  int vectors = 0, errors = 0, cyc = 0, rsp_cnt = 0, init_cnt = 0, stub_cnt = 0;
  int s, c, e, fold, lat, inits, idx, base;

  cordic_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_theta(req_theta),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sin(rsp_sin), .rsp_cos(rsp_cos),
    .rsp_err(rsp_err), .cordic_rst(cordic_rst), .cordic_init(cordic_init),
    .cordic_valid_in(cordic_valid_in), .cordic_x_i(cordic_x_i), .cordic_y_i(cordic_y_i),
    .cordic_theta_i(cordic_theta_i), .cordic_valid_out(cordic_valid_out),
    .cordic_x_o(cordic_x_o), .cordic_y_o(cordic_y_o)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rsp_cnt <= rsp_cnt + $countones(rsp_valid);
    init_cnt <= init_cnt + int'(cordic_init);
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) stub_cnt <= 0;
    else if (cordic_valid_in && stub_en) stub_cnt <= LAT;
    else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;

  function automatic int stub_sin(input logic [16:0] t);
    case (t)
      17'd7680: return 16384;
      17'd15360: return 28378;
      17'd23040: return 32768;
      default: return 0;
    endcase
  endfunction

  function automatic int stub_cos(input logic [16:0] t);
    case (t)
      17'd0: return 32768;
      17'd7680: return 28378;
      17'd15360: return 16384;
      default: return 0;
    endcase
  endfunction

  assign cordic_valid_out = stub_cnt == 1;
  assign cordic_y_o = 17'(stub_sin(cordic_theta_i));
  assign cordic_x_o = 17'(stub_cos(cordic_theta_i));

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic xact(input int i, input int theta, output int os, output int oc, output int oe,
                      output int ofold, output int olat, output int oinits, output int oidx);
    int t0, i0;
    @(negedge clk);
    i0 = init_cnt;
    req_theta[i*17 +: 17] = 17'(theta);
    req_valid[i] = 1'b1;
    #1;
    for (int k = 0; k < 20 && !req_ready[i]; k++) @(negedge clk);
    check("ready", int'(req_ready[i]), 1);
    t0 = cyc;
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    for (int k = 0; k < 200 && rsp_valid == '0; k++) @(negedge clk);
    oidx = int'(rsp_valid);
    os = int'($signed(rsp_sin));
    oc = int'($signed(rsp_cos));
    oe = int'(rsp_err);
    ofold = int'(cordic_theta_i);
    olat = cyc - t0;
    oinits = init_cnt - i0;
    @(negedge clk);
  endtask

  int tr[11] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
  int tt[11] = '{7680, 38400, -30720, 23040, -23040, 46080, -46080, 0, 51200, -46081, 7680};
  int ts[11] = '{16384, 16384, -28378, 32768, -32768, 0, 0, 0, 0, 0, 16384};
  int tc[11] = '{28378, -28378, -16384, 0, 0, -32768, -32768, 32768, 0, 0, 28378};
  int te[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
  int tf[11] = '{7680, 7680, 15360, 23040, 23040, 0, 0, 0, 0, 0, 7680};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cordic_rst", int'(cordic_rst), 1);
    check("rst_outs", int'({req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err, cordic_init,
                            cordic_valid_in, cordic_y_i, cordic_theta_i}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("run_cordic_rst", int'(cordic_rst), 0);
    check("x_seed", int'(cordic_x_i), 19899);

    for (int n = 0; n < 11; n++) begin
      xact(tr[n], tt[n], s, c, e, fold, lat, inits, idx);
      check($sformatf("rsp_idx[%0d]", n), idx, 1 << tr[n]);
      check($sformatf("sin[%0d]", n), s, ts[n]);
      check($sformatf("cos[%0d]", n), c, tc[n]);
      check($sformatf("err[%0d]", n), e, te[n]);
      if (te[n] != 0) begin
        check($sformatf("err_lat[%0d]", n), lat, 2);
        check($sformatf("err_init[%0d]", n), inits, 0);
      end else begin
        check($sformatf("fold[%0d]", n), fold, tf[n]);
        check($sformatf("init[%0d]", n), inits, 1);
      end
    end

    // all requesters held high after reset: pointer starts at 0 and wraps
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) req_theta[i*17 +: 17] = 17'd7680;
    base = rsp_cnt;
    req_valid = '1;
    #1;
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 20 && req_ready == '0; k++) @(negedge clk);
      check($sformatf("rr_grant[%0d]", n), int'(req_ready), 1 << (n % N));
      @(negedge clk);
      for (int k = 0; k < 50 && rsp_valid == '0; k++) @(negedge clk);
      check($sformatf("rr_rsp[%0d]", n), int'(rsp_valid), 1 << (n % N));
      if (n == 4) req_valid = '0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("rr_rsp_count", rsp_cnt - base, 5);

    // reset asserted while the core is busy
    stub_en = 1'b0;
    req_theta[16:0] = 17'd7680;
    req_valid[0] = 1'b1;
    #1;
    for (int k = 0; k < 20 && !req_ready[0]; k++) @(negedge clk);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    for (int k = 0; k < 20 && !cordic_valid_in; k++) @(negedge clk);
    check("busy_start", int'(cordic_valid_in), 1);
    repeat (3) @(negedge clk);
    base = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check("wait_rst_cordic_rst", int'(cordic_rst), 1);
    check("wait_rst_outs", int'({rsp_valid, rsp_sin, rsp_cos, rsp_err, cordic_init,
                                 cordic_valid_in, cordic_theta_i}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stub_en = 1'b1;
    repeat (5) @(negedge clk);
    check("wait_rst_no_rsp", rsp_cnt - base, 0);
    xact(2, 38400, s, c, e, fold, lat, inits, idx);
    check("post_rst_idx", idx, 4);
    check("post_rst_sin", s, 16384);
    check("post_rst_cos", c, -28378);

`ifdef CORDIC_SCHED_TIMEOUT_EN
    stub_en = 1'b0;
    xact(3, 7680, s, c, e, fold, lat, inits, idx);
    check("tmo_idx", idx, 8);
    check("tmo_err", e, 1);
    check("tmo_sincos", s | c, 0);
    check("tmo_lat", lat, TMO + 4);
    stub_en = 1'b1;
    xact(0, -30720, s, c, e, fold, lat, inits, idx);
    check("post_tmo_sin", s, -28378);
    check("post_tmo_err", e, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
